// File: rtl/vga_pkg.sv
// Shared definitions for the mini-VGA frame buffer: resolution defaults,
// derived widths, CPU register map, CTRL bit positions and writer FSM states.
package vga_pkg;
  localparam int HRES_DEF = 160;
  localparam int VRES_DEF = 120;
  localparam int XW_DEF   = $clog2(HRES_DEF);
  localparam int YW_DEF   = $clog2(VRES_DEF);

  localparam logic [1:0] REG_XPOS = 2'd0;
  localparam logic [1:0] REG_YPOS = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_CLEAR   = 0;
  localparam int CTRL_OVF_CLR = 1;
  localparam int CTRL_INVERT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNPACK = 2'd1,
    ST_CLEAR  = 2'd2
  } wr_state_e;
endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO for queued pixel bytes; DEPTH must be a power of two.
module vram_wr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  // a push into a full FIFO is fine when the head leaves in the same cycle
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/vram_writer.sv
// CPU write port of the mini-VGA frame buffer: queues pixel bytes and unpacks
// them into single-pixel RAM writes during blanking. VRAM_WRITER_INVERT_EN adds CTRL bit2 invert.
module vram_writer
  import vga_pkg::*;
#(
  parameter int HRESOLUTION = HRES_DEF,
  parameter int VRESOLUTION = VRES_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           visible,
  input  logic                           cpu_wr,
  input  logic [1:0]                     cpu_addr,
  input  logic [7:0]                     cpu_data,
  output logic                           cpu_busy,
  output logic                           overflow,
  output logic                           ram_we,
  output logic [$clog2(VRESOLUTION)-1:0] ram_row,
  output logic [$clog2(HRESOLUTION)-1:0] ram_col,
  output logic                           ram_bit
);
  localparam int XW = $clog2(HRESOLUTION);
  localparam int YW = $clog2(VRESOLUTION);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    px;
  } entry_t;

  wr_state_e     state;
  logic [XW-1:0] xpos, ux, ccol;
  logic [YW-1:0] ypos, uy, crow;
  logic [7:0]    ubyte, xr;
  logic [2:0]    k;
  logic [XW:0]   x_inc;
  logic [YW:0]   y_inc;
  logic          clr_pend, clearing, inv;
  logic          wr_x, wr_y, wr_data, wr_ctrl, data_ok;
  logic          push, pop, flush, fifo_full, fifo_empty;
  entry_t        fifo_din, fifo_dout;

  assign wr_x    = cpu_wr && (cpu_addr == REG_XPOS);
  assign wr_y    = cpu_wr && (cpu_addr == REG_YPOS);
  assign wr_data = cpu_wr && (cpu_addr == REG_DATA);
  assign wr_ctrl = cpu_wr && (cpu_addr == REG_CTRL);

  assign clearing = clr_pend || (state == ST_CLEAR);
  assign cpu_busy = fifo_full || clearing;

  // Bytes stay queued through the visible region so FIFO_DEPTH bytes can be
  // absorbed before the CPU sees busy; the pop happens in the first blanking cycle.
  assign pop     = (state == ST_IDLE) && !clr_pend && !fifo_empty && !visible;
  assign flush   = (state == ST_IDLE) && clr_pend;
  assign data_ok = !clearing && (!fifo_full || pop);
  assign push    = wr_data && data_ok;

  assign fifo_din = {xpos, ypos, cpu_data};
  assign xr       = {cpu_data[7:3], 3'b000};
  assign x_inc    = {1'b0, xpos} + (XW+1)'(8);
  assign y_inc    = {1'b0, ypos} + (YW+1)'(1);

  vram_wr_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef VRAM_WRITER_INVERT_EN
  always_ff @(posedge clk) begin
    if (reset)        inv <= 1'b0;
    else if (wr_ctrl) inv <= cpu_data[CTRL_INVERT];
  end
`else
  assign inv = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      xpos     <= '0;
      ypos     <= '0;
      overflow <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      if (flush) clr_pend <= 1'b0;
      if (wr_x) xpos <= (int'(xr) >= HRESOLUTION) ? '0 : XW'(xr);
      if (wr_y) ypos <= (int'(cpu_data) >= VRESOLUTION) ? '0 : YW'(cpu_data);
      if (wr_data) begin
        if (data_ok) begin
          if (int'(x_inc) >= HRESOLUTION) begin
            xpos <= '0;
            ypos <= (int'(y_inc) >= VRESOLUTION) ? '0 : y_inc[YW-1:0];
          end else begin
            xpos <= x_inc[XW-1:0];
          end
        end else begin
          overflow <= 1'b1;
        end
      end
      if (wr_ctrl) begin
        if (cpu_data[CTRL_CLEAR] && !clearing) clr_pend <= 1'b1;
        if (cpu_data[CTRL_OVF_CLR])            overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      k       <= '0;
      ux      <= '0;
      uy      <= '0;
      ubyte   <= '0;
      crow    <= '0;
      ccol    <= '0;
      ram_we  <= 1'b0;
      ram_row <= '0;
      ram_col <= '0;
      ram_bit <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (flush) begin
            crow  <= '0;
            ccol  <= '0;
            state <= ST_CLEAR;
          end else if (pop) begin
            ux    <= fifo_dout.x;
            uy    <= fifo_dout.y;
            ubyte <= fifo_dout.px;
            k     <= '0;
            state <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          if (!visible) begin
            ram_we  <= 1'b1;
            ram_row <= uy;
            ram_col <= ux + XW'(k);
            ram_bit <= ubyte[3'd7 - k] ^ inv;
            k       <= k + 1'b1;
            if (k == 3'd7) state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (!visible) begin
            ram_we  <= 1'b1;
            ram_row <= crow;
            ram_col <= ccol;
            ram_bit <= inv;
            if (int'(ccol) == HRESOLUTION - 1) begin
              ccol <= '0;
              if (int'(crow) == VRESOLUTION - 1) state <= ST_IDLE;
              else                               crow  <= crow + 1'b1;
            end else begin
              ccol <= ccol + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: table of register/DATA vectors plus
// hand-written sequences for backpressure, visible stalls, clear and reset.
module tb_vram_writer;
  logic       clk = 1'b0;
  logic       reset, visible, cpu_wr;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_busy, overflow, ram_we, ram_bit;
  logic [6:0] ram_row;
  logic [7:0] ram_col;

  vram_writer dut (
    .clk      (clk),
    .reset    (reset),
    .visible  (visible),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_busy (cpu_busy),
    .overflow (overflow),
    .ram_we   (ram_we),
    .ram_row  (ram_row),
    .ram_col  (ram_col),
    .ram_bit  (ram_bit)
  );

  always #5 clk = ~clk;

  typedef struct { int t; int row; int col; int b; } cap_t;
  typedef struct { bit sx; int x; bit sy; int y; logic [7:0] d; int er; int ec; } vec_t;

  cap_t capq[$];
  int   cyc = 0;
  int   tests = 0, fails = 0;
  int   clr_cnt = 0, clr_err = 0, clr_base = 0;
  bit   clr_mode = 1'b0, clr_val = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (clr_mode) begin
        if (int'(ram_row) != (clr_cnt - clr_base) / 160 ||
            int'(ram_col) != (clr_cnt - clr_base) % 160 || ram_bit !== clr_val)
          clr_err <= clr_err + 1;
        clr_cnt <= clr_cnt + 1;
      end else begin
        capq.push_back('{t: cyc, row: int'(ram_row), col: int'(ram_col), b: int'(ram_bit)});
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_data = d;
    cpu_wr   = 1'b1;
    @(posedge clk);
    #1;
    cpu_wr   = 1'b0;
  endtask

  task automatic wait_w(input int n, input int budget, input string nm);
    int i = 0;
    while (capq.size() < n && i < budget) begin
      step();
      i++;
    end
    chk({nm, "_wait"}, int'(capq.size() >= n), 1);
  endtask

  // pixel k of a byte packed as {row, col, bit} for a single comparison
  task automatic check_byte(input string nm, input int base, input int row, input int col,
                            input logic [7:0] d, input bit inv);
    for (int k = 0; k < 8; k++) begin
      int act, exp;
      logic [7:0] dd;
      dd  = d;
      exp = (row << 16) | ((col + k) << 1) | int'(dd[7-k] ^ inv);
      if (base + k < capq.size())
        act = (capq[base+k].row << 16) | (capq[base+k].col << 1) | capq[base+k].b;
      else
        act = -1;
      chk($sformatf("%s_px%0d", nm, k), act, exp);
    end
  endtask

  task automatic do_clear(input logic [7:0] cmd, input bit val, input string nm);
    int i = 0;
    clr_base = clr_cnt;
    clr_val  = val;
    clr_mode = 1'b1;
    wr(2'd3, cmd);
    chk({nm, "_busy_start"}, int'(cpu_busy), 1);
    while ((clr_cnt - clr_base) < 19200 && i < 20000) begin
      step();
      i++;
    end
    step();
    chk({nm, "_busy_end"}, int'(cpu_busy), 0);
    repeat (5) step();
    clr_mode = 1'b0;
    chk({nm, "_count"}, clr_cnt - clr_base, 19200);
    chk({nm, "_order_value_errs"}, clr_err, 0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v[8];
    int   t0;
    v[0] = '{1, 16,  1, 5,   8'hA5, 5,   16};
    v[1] = '{0, 0,   0, 0,   8'h3C, 5,   24};
    v[2] = '{1, 19,  1, 7,   8'h81, 7,   16};
    v[3] = '{1, 200, 1, 130, 8'hFF, 0,   0};
    v[4] = '{1, 152, 1, 119, 8'h0F, 119, 152};
    v[5] = '{0, 0,   0, 0,   8'hD2, 0,   0};
    v[6] = '{1, 159, 0, 0,   8'h55, 0,   152};
    v[7] = '{0, 0,   0, 0,   8'hAA, 1,   0};

    reset = 1'b1; visible = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({cpu_busy, overflow, ram_we, ram_row, ram_col, ram_bit}), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      capq.delete();
      if (v[i].sx) wr(2'd0, 8'(v[i].x));
      if (v[i].sy) wr(2'd1, 8'(v[i].y));
      wr(2'd2, v[i].d);
      wait_w(8, 40, $sformatf("vec%0d", i));
      repeat (3) step();
      check_byte($sformatf("vec%0d", i), 0, v[i].er, v[i].ec, v[i].d, 1'b0);
    end

    // backpressure while visible
    capq.delete();
    visible = 1'b1;
    wr(2'd0, 8'd0);
    wr(2'd1, 8'd10);
    for (int j = 0; j < 5; j++) begin
      wr(2'd2, 8'(8'h11 * (j + 1)));
      if (j == 2) chk("bp_busy_after3", int'(cpu_busy), 0);
      if (j == 3) chk("bp_busy_after4", int'(cpu_busy), 1);
    end
    chk("bp_overflow", int'(overflow), 1);
    repeat (5) step();
    chk("bp_no_write_visible", capq.size(), 0);
    visible = 1'b0;
    wait_w(32, 100, "bp");
    repeat (20) step();
    chk("bp_count", capq.size(), 32);
    for (int j = 0; j < 4; j++)
      check_byte($sformatf("bp_b%0d", j), 8 * j, 10, 8 * j, 8'(8'h11 * (j + 1)), 1'b0);
    chk("bp_busy_drained", int'(cpu_busy), 0);
    wr(2'd3, 8'h02);
    chk("bp_overflow_clr", int'(overflow), 0);

    // visible stall mid-unpack
    capq.delete();
    wr(2'd0, 8'd32);
    wr(2'd1, 8'd20);
    wr(2'd2, 8'h96);
    t0 = cyc;
    repeat (3) begin @(posedge clk); #1; end
    visible = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    visible = 1'b0;
    wait_w(8, 40, "stall");
    repeat (3) step();
    check_byte("stall", 0, 20, 32, 8'h96, 1'b0);
    if (capq.size() >= 8) begin
      chk("stall_latency", capq[0].t - t0, 2);
      chk("stall_b1_gap", capq[1].t - capq[0].t, 1);
      chk("stall_b2_gap", capq[2].t - capq[1].t, 4);
      chk("stall_tail", capq[7].t - capq[2].t, 5);
    end

    do_clear(8'h01, 1'b0, "clr");

`ifdef VRAM_WRITER_INVERT_EN
    do_clear(8'h05, 1'b1, "clr_inv");
    capq.delete();
    wr(2'd0, 8'd0);
    wr(2'd1, 8'd0);
    wr(2'd2, 8'hA5);
    wait_w(8, 40, "inv");
    repeat (3) step();
    check_byte("inv", 0, 0, 0, 8'hA5, 1'b1);
    wr(2'd3, 8'h00);
`endif

    // reset in the middle of an unpack, with a second byte still queued
    capq.delete();
    wr(2'd0, 8'd40);
    wr(2'd2, 8'hFF);
    wr(2'd2, 8'h0F);
    begin
      int i = 0;
      while (capq.size() < 4 && i < 30) begin
        step();
        i++;
      end
    end
    chk("rst_reached_bit4", capq.size(), 4);
    reset = 1'b1;
    step();
    chk("rst_outputs", int'({cpu_busy, overflow, ram_we, ram_row, ram_col, ram_bit}), 0);
    reset = 1'b0;
    repeat (12) step();
    chk("rst_no_more_writes", capq.size(), 4);
    capq.delete();
    wr(2'd2, 8'h80);
    wait_w(8, 40, "rst_after");
    repeat (3) step();
    check_byte("rst_after", 0, 0, 0, 8'h80, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vram_writer.md
Name: vram_writer

Overview:
- CPU-side write port of the mini-VGA frame buffer; the display path reads the buffer, this block fills it.
- Accepts 8-bit register writes from the JML-8 bus and queues pixel bytes in a small FIFO.
- Unpacks each queued byte into 8 single-pixel RAM writes, issued only while the display path is not reading (visible low).
- Also provides a full-screen clear command.

Parameters:
- HRESOLUTION, 160, pixels per line; must be a multiple of 8.
- VRESOLUTION, 120, lines per frame.
- FIFO_DEPTH, 4, queued pixel bytes; power of two, at least 2.

Ports:
- clk  in  1  pixel clock, shared with the VGA timing logic.
- reset  in  1  synchronous, active-high.
- visible  in  1  display is in the active region; RAM writes are forbidden while high.
- cpu_wr  in  1  single-cycle write strobe from the CPU bus.
- cpu_addr  in  2  register select: 0=XPOS, 1=YPOS, 2=DATA, 3=CTRL.
- cpu_data  in  8  write data.
- cpu_busy  out  1  FIFO full or clear in progress.
- overflow  out  1  sticky: a DATA write was dropped.
- ram_we  out  1  pixel write enable.
- ram_row  out  $clog2(VRESOLUTION)  pixel row.
- ram_col  out  $clog2(HRESOLUTION)  pixel column.
- ram_bit  out  1  pixel value.

Behaviour:
Reset:
- All outputs are 0.
- XPOS and YPOS are 0, the FIFO is empty, and the FSM is in IDLE.
- Reset mid-unpack or mid-clear aborts immediately; no further ram_we pulses follow.

Register writes (take effect on the clk edge where cpu_wr=1):
- XPOS: the value is rounded down to a multiple of 8. If the value is >= HRESOLUTION, XPOS becomes 0.
- YPOS: if the value is >= VRESOLUTION, YPOS becomes 0.
- DATA, FIFO not full and not clearing:
  - Enqueue {XPOS, YPOS, byte}; coordinates are captured at enqueue time.
  - Then XPOS += 8. If the result reaches HRESOLUTION, XPOS=0 and YPOS += 1.
  - If YPOS then reaches VRESOLUTION, YPOS=0.
- DATA, FIFO full or clearing: the write is dropped, overflow is set, and the pointers are unchanged.
- CTRL bit0=1: request a clear. Ignored while a clear is already in progress.
- CTRL bit1=1: clear overflow.
- Other CTRL bits are ignored.

cpu_busy:
- Asserted from the edge after the FIFO becomes full or a clear starts.
- Combinational from the registered state.

FSM:
- IDLE:
  - A pending clear has priority: go to CLEAR.
  - Otherwise, if the FIFO is not empty, pop the head into the unpack register and go to UNPACK.
- UNPACK:
  - Holds a bit index k = 0..7, MSB first; bit 7 is the leftmost pixel.
  - On each cycle with visible=0: ram_we=1, ram_row=y, ram_col=x+k, ram_bit=byte[7-k], then k++.
  - After k=7, return to IDLE.
  - A cycle with visible=1 stalls with ram_we=0, and k holds.
  - Latency: the first ram_we comes 2 cycles after the DATA strobe when the FIFO was empty and the block is in blanking.
- CLEAR:
  - Sweeps row 0..VRESOLUTION-1 and col 0..HRESOLUTION-1, row-major, one pixel per blanking cycle, with ram_bit=0.
  - Stalls when visible=1.
  - Returns to IDLE after the last pixel.
  - The FIFO is flushed at clear start.

Timing of ram_* outputs:
- ram_we, ram_row, ram_col and ram_bit are registered.
- They are qualified by visible sampled in the same cycle, so the row/col they present are never written during visible.

Simultaneous events:
- An enqueue and a pop in the same cycle on a full FIFO are accepted, so the count is unchanged.
- A DATA write in the same cycle as a clear request is dropped.

Optional Feature:
- Macro: VRAM_WRITER_INVERT_EN.
- Defined:
  - CTRL bit2 becomes a registered invert flag, reset 0.
  - While the flag is set, ram_bit = ~byte bit during UNPACK, and clear writes 1s.
- Undefined:
  - CTRL bit2 is ignored.
  - Pixels are written as given, and clear writes 0s.

Decomposition:
- Shared package vga_pkg holds:
  - the HRESOLUTION/VRESOLUTION defaults;
  - the derived widths;
  - the register address localparams (XPOS, YPOS, DATA, CTRL);
  - the CTRL bit positions;
  - the FSM state encoding.
- Sub-module vram_wr_fifo: synchronous FIFO, parameterised width and depth, with push, pop, full, empty and dout. It carries {x, y, byte} entries.

Test Plan:
- Write XPOS=16, YPOS=5, DATA=0xA5 during blanking -> 8 ram_we pulses at row 5, cols 16..23, bits 1,0,1,0,0,1,0,1; XPOS reads internally as 24.
- Write XPOS=152, YPOS=119, then DATA twice -> second byte lands at row 0, col 0 (x and y wrap).
- Hold visible=1 and write 5 DATA bytes -> no ram_we; cpu_busy high after the 4th; 5th is dropped and overflow=1. Then visible=0 -> exactly 32 writes. CTRL=0x02 clears overflow.
- Toggle visible mid-unpack (high for 3 cycles after the 2nd bit) -> ram_we gaps exactly 3 cycles; all 8 bits are still written in order.
- CTRL=0x01 with visible tied 0 -> 19200 writes of 0 covering every row/col once; busy drops on the following cycle. With INVERT_EN and bit2 set, the writes are 1s instead.
- Assert reset at the 4th bit of an unpack -> ram_we is 0 from the next edge; FIFO empty; outputs all 0.
